// File: rtl/bp_stall_hist_ctrl.sv
// Stall-reason histogram: one saturating counter per stall reason plus retired instructions, with start/stop/clear/read host commands.
// Reads return one cycle after acceptance and hold until consumed; cmd_ready_o drops while a response is pending or during a clear sweep.
module bp_stall_hist_ctrl #(
  parameter int cnt_width_p = 32,
  parameter int num_bins_p  = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   sample_v_i,
  input  logic                   instret_i,
  input  logic [4:0]             stall_reason_i,
  input  logic                   freeze_i,
  input  logic                   cmd_v_i,
  input  logic [1:0]             cmd_op_i,
  input  logic [4:0]             cmd_addr_i,
  output logic                   cmd_ready_o,
  output logic                   resp_v_o,
  output logic [cnt_width_p-1:0] resp_data_o,
  input  logic                   resp_yumi_i,
  output logic                   running_o,
  output logic                   clearing_o
);

  typedef enum logic [1:0] {
    STOP_S  = 2'd0,
    RUN_S   = 2'd1,
    CLEAR_S = 2'd2
  } state_e;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [4:0]             last_bin_lp = 5'(num_bins_p - 1);
  localparam logic [cnt_width_p-1:0] one_lp      = cnt_width_p'(1);

  state_e                 state_r, state_n;
  logic [4:0]             sweep_r;
  logic [cnt_width_p-1:0] bins_r [num_bins_p];
  logic                   resp_v_r;
  logic [cnt_width_p-1:0] resp_data_r;

  logic                   cmd_fire;
  logic                   count_en;
  logic [4:0]             bin_idx;
  logic [cnt_width_p-1:0] rd_data;

  assign cmd_ready_o = (state_r != CLEAR_S) & ~resp_v_r;
  assign cmd_fire    = cmd_v_i & cmd_ready_o;
  assign running_o   = (state_r == RUN_S);
  assign clearing_o  = (state_r == CLEAR_S);
  assign resp_v_o    = resp_v_r;
  assign resp_data_o = resp_data_r;

  // A clear accepted while running wins over a sample in the same cycle.
  assign count_en = (state_r == RUN_S) & sample_v_i & ~freeze_i
                  & ~(cmd_fire & (cmd_op_i == OP_CLEAR));

  // The top reason code aliases the retired-instruction bin, so it folds to "unknown".
  assign bin_idx = instret_i                        ? last_bin_lp :
                   (stall_reason_i >= last_bin_lp)  ? 5'd0        : stall_reason_i;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < num_bins_p; i++) begin
      if (cmd_addr_i == 5'(i)) rd_data = bins_r[i];
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      CLEAR_S: begin
        if (sweep_r == last_bin_lp) state_n = STOP_S;
      end
      default: begin
        if (cmd_fire) begin
          case (cmd_op_i)
            OP_START: state_n = RUN_S;
            OP_STOP:  state_n = STOP_S;
            OP_CLEAR: state_n = CLEAR_S;
            default:  state_n = state_r;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= STOP_S;
    end else begin
      state_r <= state_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sweep_r <= '0;
    end else if (state_r == CLEAR_S) begin
      sweep_r <= (sweep_r == last_bin_lp) ? 5'd0 : sweep_r + 5'd1;
    end else if (cmd_fire && (cmd_op_i == OP_CLEAR)) begin
      sweep_r <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_bins_p; i++) bins_r[i] <= '0;
    end else begin
      for (int i = 0; i < num_bins_p; i++) begin
        if (state_r == CLEAR_S) begin
          if (sweep_r == 5'(i)) bins_r[i] <= '0;
        end else if (count_en && (bin_idx == 5'(i)) && !(&bins_r[i])) begin
          bins_r[i] <= bins_r[i] + one_lp;
        end
      end
    end
  end

  // Read data is taken from the pre-edge counter, so a same-cycle increment is not visible.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_r    <= 1'b0;
      resp_data_r <= '0;
    end else if (cmd_fire && (cmd_op_i == OP_READ)) begin
      resp_v_r    <= 1'b1;
      resp_data_r <= rd_data;
    end else if (resp_yumi_i) begin
      resp_v_r    <= 1'b0;
    end
  end

endmodule
